// File: rtl/led_rotation_monitor.sv
// led_rotation_monitor
//
// Receive-side checker for a rotating LED pattern. The LED word is
// synchronized into the clk domain. Each change of the word must be a
// one-position left rotation arriving EXPECTED_PERIOD +/- TOLERANCE cycles
// after the previous change. After LOCK_STEPS consecutive good steps the
// monitor locks. While locked it reports every step. The first bad step or
// stall moves it into a sticky FAULT state that only clear or reset leaves.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   leds_in      observed LED word, asynchronous to clk
//   clear        synchronous clear of state, fault and counters
//   locked       high while locked onto the rotation
//   fault        high while in the sticky fault state
//   fault_code   00 none, 01 bad pattern, 10 early step, 11 stall/late
//   step_pulse   one-cycle pulse per good step while locked
//   step_count   good steps while locked, wraps modulo 2^16
//   last_period  measured period of the most recent change event
module led_rotation_monitor #(
  parameter int unsigned EXPECTED_PERIOD = 25_000_001,
  parameter int unsigned TOLERANCE       = 2,
  parameter int unsigned LOCK_STEPS      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  leds_in,
  input  logic        clear,
  output logic        locked,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        step_pulse,
  output logic [15:0] step_count,
  output logic [31:0] last_period
);

  localparam logic [31:0] WIN_LO = 32'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [31:0] WIN_HI = 32'(EXPECTED_PERIOD + TOLERANCE);
  localparam int          GW     = (LOCK_STEPS < 2) ? 1 : $clog2(LOCK_STEPS + 1);
  localparam logic [GW-1:0] LOCK_TARGET = GW'(LOCK_STEPS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_PATTERN = 2'b01;
  localparam logic [1:0] CODE_EARLY   = 2'b10;
  localparam logic [1:0] CODE_STALL   = 2'b11;

  logic [7:0]    sync1;
  logic [7:0]    s;
  logic [7:0]    p;
  logic [1:0]    state;
  logic [GW-1:0] good_cnt;
  logic [31:0]   period_cnt;

  logic          change;
  logic          rot_ok;
  logic          early;
  logic          late;
  logic          good_step;
  logic          timeout;

  logic [1:0]    state_next;
  logic [GW-1:0] good_cnt_next;
  logic [1:0]    code_next;
  logic          pulse_next;
  logic [15:0]   count_next;
  logic [31:0]   period_next;
  logic [31:0]   last_next;

  // Two-flop synchronizer plus a copy of the previous synchronized word.
  // clear deliberately leaves these alone so a change in the clear cycle
  // is consumed rather than replayed afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      s     <= 8'h00;
      p     <= 8'h00;
    end else begin
      sync1 <= leds_in;
      s     <= sync1;
      p     <= s;
    end
  end

  // Event decode from the synchronized word and the running period counter.
  always_comb begin
    change    = (s != p);
    rot_ok    = (s == {p[6:0], p[7]});
    early     = (period_cnt < WIN_LO);
    late      = (period_cnt > WIN_HI);
    good_step = change && rot_ok && !early && !late;
    timeout   = !change && late;
  end

  // Period counter restarts at 1 on every change and saturates at all-ones.
  // last_period is not touched by the IDLE start event because that event
  // has no meaningful predecessor.
  always_comb begin
    period_next = period_cnt;
    last_next   = last_period;
    if (clear) begin
      period_next = 32'd0;
      last_next   = 32'd0;
    end else begin
      if (change) begin
        period_next = 32'd1;
      end else if (period_cnt != 32'hFFFF_FFFF) begin
        period_next = period_cnt + 32'd1;
      end
      if (change && (state != IDLE)) begin
        last_next = period_cnt;
      end
    end
  end

  // Lock/fault state machine. In LOCKED the pattern check takes priority
  // over the timing checks; clear overrides whatever else happens.
  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    code_next     = fault_code;
    pulse_next    = 1'b0;
    count_next    = step_count;
    case (state)
      IDLE: begin
        if (change) begin
          state_next    = ACQUIRE;
          good_cnt_next = '0;
        end
      end
      ACQUIRE: begin
        if (good_step) begin
          good_cnt_next = good_cnt + 1'b1;
          if (good_cnt_next == LOCK_TARGET) begin
            state_next = LOCKED;
          end
        end else if (change) begin
          good_cnt_next = '0;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        if (change) begin
          if (!rot_ok) begin
            state_next = FAULT;
            code_next  = CODE_PATTERN;
          end else if (early) begin
            state_next = FAULT;
            code_next  = CODE_EARLY;
          end else if (late) begin
            state_next = FAULT;
            code_next  = CODE_STALL;
          end else begin
            pulse_next = 1'b1;
            count_next = step_count + 16'd1;
          end
        end else if (timeout) begin
          state_next = FAULT;
          code_next  = CODE_STALL;
        end
      end
      default: begin
        state_next = FAULT;
      end
    endcase
    if (clear) begin
      state_next    = IDLE;
      good_cnt_next = '0;
      code_next     = CODE_NONE;
      pulse_next    = 1'b0;
      count_next    = 16'd0;
    end
  end

  // State and registered outputs; locked/fault are decoded from the next
  // state so they change in the same cycle as the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      good_cnt    <= '0;
      period_cnt  <= 32'd0;
      locked      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= CODE_NONE;
      step_pulse  <= 1'b0;
      step_count  <= 16'd0;
      last_period <= 32'd0;
    end else begin
      state       <= state_next;
      good_cnt    <= good_cnt_next;
      period_cnt  <= period_next;
      locked      <= (state_next == LOCKED);
      fault       <= (state_next == FAULT);
      fault_code  <= code_next;
      step_pulse  <= pulse_next;
      step_count  <= count_next;
      last_period <= last_next;
    end
  end

endmodule

// File: tb/tb_led_rotation_monitor.sv
// tb_led_rotation_monitor
//
// Directed bench for led_rotation_monitor with EXPECTED_PERIOD=8,
// TOLERANCE=1, LOCK_STEPS=3. Stimulus drives LED words on the falling edge
// and queues the hand-computed output tuple together with the cycle at which
// it must appear. A separate monitor watches the outputs on every falling
// edge and, whenever any output changes, pops and compares the next entry.
//
// Ports: none (top-level bench).
module tb_led_rotation_monitor;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        clear   = 1'b0;
  logic [7:0]  leds_in = 8'h00;
  logic        locked;
  logic        fault;
  logic [1:0]  fault_code;
  logic        step_pulse;
  logic [15:0] step_count;
  logic [31:0] last_period;

  typedef struct packed {
    logic        locked;
    logic        fault;
    logic [1:0]  code;
    logic        pulse;
    logic [15:0] count;
    logic [31:0] last;
  } obs_t;

  obs_t exp_q[$];
  int   cyc_q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  led_rotation_monitor #(
    .EXPECTED_PERIOD(8),
    .TOLERANCE(1),
    .LOCK_STEPS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .leds_in(leds_in),
    .clear(clear),
    .locked(locked),
    .fault(fault),
    .fault_code(fault_code),
    .step_pulse(step_pulse),
    .step_count(step_count),
    .last_period(last_period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input bit l, input bit f, input logic [1:0] c,
                              input bit pl, input int cnt, input int last);
    obs_t o;
    o.locked = l;
    o.fault  = f;
    o.code   = c;
    o.pulse  = pl;
    o.count  = 16'(cnt);
    o.last   = 32'(last);
    return o;
  endfunction

  function automatic obs_t snapshot();
    return {locked, fault, fault_code, step_pulse, step_count, last_period};
  endfunction

  // Queue an expected output tuple that must appear 'offset' cycles from now.
  task automatic expect_at(input int offset, input obs_t v);
    cyc_q.push_back(cyc + offset);
    exp_q.push_back(v);
  endtask

  // Wait 'gap' falling edges, then present a new LED word.
  task automatic apply_stimulus(input logic [7:0] v, input int gap);
    repeat (gap) @(negedge clk);
    leds_in = v;
  endtask

  // A good step while locked: pulse with the new count, then pulse low.
  task automatic locked_step(input logic [7:0] v, input int gap,
                             input int cnt, input int per);
    apply_stimulus(v, gap);
    expect_at(3, mk(1, 0, 2'b00, 1, cnt, per));
    expect_at(4, mk(1, 0, 2'b00, 0, cnt, per));
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    expect_at(1, mk(0, 0, 2'b00, 0, 0, 0));
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_output(input string name, input obs_t e);
    obs_t a;
    a = snapshot();
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got locked=%0b fault=%0b code=%b pulse=%0b count=%0d last=%0d, expected locked=%0b fault=%0b code=%b pulse=%0b count=%0d last=%0d",
               name, a.locked, a.fault, a.code, a.pulse, a.count, a.last,
               e.locked, e.fault, e.code, e.pulse, e.count, e.last);
    end
  endtask

  // Monitor: any change of the output tuple is one DUT response.
  initial begin
    obs_t prev;
    obs_t cur;
    obs_t e;
    int   ec;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = snapshot();
      if (mon_en && (cur !== prev)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_change at cyc=%0d: locked=%0b fault=%0b code=%b pulse=%0b count=%0d last=%0d",
                   cyc, cur.locked, cur.fault, cur.code, cur.pulse, cur.count, cur.last);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          if ((cur !== e) || (cyc != ec)) begin
            errors++;
            $display("[TB] FAIL response: got cyc=%0d locked=%0b fault=%0b code=%b pulse=%0b count=%0d last=%0d, expected cyc=%0d locked=%0b fault=%0b code=%b pulse=%0b count=%0d last=%0d",
                     cyc, cur.locked, cur.fault, cur.code, cur.pulse, cur.count, cur.last,
                     ec, e.locked, e.fault, e.code, e.pulse, e.count, e.last);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    check_output("reset", mk(0, 0, 2'b00, 0, 0, 0));
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Lock-up: start event, three good steps, then locked steps incl. 7/9.
    apply_stimulus(8'h1F, 2);
    apply_stimulus(8'h3E, 8);
    expect_at(3, mk(0, 0, 2'b00, 0, 0, 8));
    apply_stimulus(8'h7C, 8);
    apply_stimulus(8'hF8, 8);
    expect_at(3, mk(1, 0, 2'b00, 0, 0, 8));
    locked_step(8'hF1, 8, 1, 8);
    locked_step(8'hE3, 8, 2, 8);
    locked_step(8'hC7, 7, 3, 7);
    locked_step(8'h8F, 9, 4, 9);
    locked_step(8'h1F, 8, 5, 8);

    // Asynchronous reset while locked with step_count=5.
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    expect_at(0, mk(0, 0, 2'b00, 0, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // The held word 0x1F is the new start event; relock and count from 1.
    apply_stimulus(8'h3E, 8);
    expect_at(3, mk(0, 0, 2'b00, 0, 0, 8));
    apply_stimulus(8'h7C, 8);
    apply_stimulus(8'hF8, 8);
    expect_at(3, mk(1, 0, 2'b00, 0, 0, 8));
    locked_step(8'hF1, 8, 1, 8);
    locked_step(8'hE3, 8, 2, 8);
    locked_step(8'hC7, 8, 3, 8);
    locked_step(8'h8F, 8, 4, 8);
    locked_step(8'h1F, 8, 5, 8);

    // Bad pattern, then a later rotation only updates last_period.
    apply_stimulus(8'h3F, 8);
    expect_at(3, mk(0, 1, 2'b01, 0, 5, 8));
    apply_stimulus(8'h7E, 6);
    expect_at(3, mk(0, 1, 2'b01, 0, 5, 6));

    // clear in the same cycle the next change is decoded.
    apply_stimulus(8'hFC, 8);
    expect_at(3, mk(0, 0, 2'b00, 0, 0, 0));
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // New acquisition after clear, then an early step.
    apply_stimulus(8'hF9, 8);
    apply_stimulus(8'hF3, 8);
    expect_at(3, mk(0, 0, 2'b00, 0, 0, 8));
    apply_stimulus(8'hE7, 8);
    apply_stimulus(8'hCF, 8);
    expect_at(3, mk(1, 0, 2'b00, 0, 0, 8));
    apply_stimulus(8'h9F, 5);
    expect_at(3, mk(0, 1, 2'b10, 0, 0, 5));
    repeat (8) @(negedge clk);
    clear_pulse();

    // Relock, then a late step after 10 cycles.
    apply_stimulus(8'h3F, 4);
    apply_stimulus(8'h7E, 8);
    expect_at(3, mk(0, 0, 2'b00, 0, 0, 8));
    apply_stimulus(8'hFC, 8);
    apply_stimulus(8'hF9, 8);
    expect_at(3, mk(1, 0, 2'b00, 0, 0, 8));
    apply_stimulus(8'hF3, 10);
    expect_at(3, mk(0, 1, 2'b11, 0, 0, 10));
    repeat (8) @(negedge clk);
    clear_pulse();

    // Relock, then hold the LEDs: stall fault 10 cycles after the last event.
    apply_stimulus(8'hE7, 4);
    apply_stimulus(8'hCF, 8);
    expect_at(3, mk(0, 0, 2'b00, 0, 0, 8));
    apply_stimulus(8'h9F, 8);
    apply_stimulus(8'h3F, 8);
    expect_at(3, mk(1, 0, 2'b00, 0, 0, 8));
    expect_at(13, mk(0, 1, 2'b11, 0, 0, 8));
    repeat (20) @(negedge clk);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected responses never appeared, required 0",
               exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
